// File: rtl/mac_tx_ctrl_pkg.sv
// Shared MAC TX constants and the sequencer state type.
// Header count, channel count and minimum IFG feed the defaults of mac_tx_ctrl.
package mac_tx_ctrl_pkg;

  localparam int N_CHANNELS        = 8;
  localparam int MAC_HDR_CNT       = 1;
  localparam int W_MAC_HDR_CNT     = (MAC_HDR_CNT > 1) ? $clog2(MAC_HDR_CNT) : 1;
  localparam int MAC_MIN_IFG_BYTES = 12;
  localparam int MAC_IFG_WORDS     = (MAC_MIN_IFG_BYTES + N_CHANNELS - 1) / N_CHANNELS;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA,
    ERR,
    IFG
  } tx_ctrl_state_e;

endpackage

// File: rtl/mac_tx_ctrl.sv
// TX MAC sequencer: pops frames from the TX buffer and strobes framegen through
// header, data and inter-frame gap, aborting the frame on buffer underflow.
module mac_tx_ctrl
  import mac_tx_ctrl_pkg::*;
#(
  parameter int IFG_WORDS     = MAC_IFG_WORDS,
  parameter int W_FRAME_WORDS = 11
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic                     i_clk_en,
  input  logic                     i_frame_rdy,
  input  logic [W_FRAME_WORDS-1:0] i_frame_words,
  output logic                     o_frame_ack,
  output logic                     o_buf_ren,
  input  logic                     i_buf_underflow,
  output logic                     o_frame_abort,
  output logic                     o_gen_hdr,
  output logic [W_MAC_HDR_CNT-1:0] o_hdr_id,
  output logic                     o_gen_data,
  output logic                     o_gen_idle,
  output logic                     o_gen_ifg,
  output logic                     o_gen_error,
  output logic                     o_busy
);

  localparam int W_IFG = (IFG_WORDS > 1) ? $clog2(IFG_WORDS) : 1;

  localparam logic [W_MAC_HDR_CNT-1:0] HDR_LAST = W_MAC_HDR_CNT'(MAC_HDR_CNT - 1);
  localparam logic [W_IFG-1:0]         IFG_LOAD = W_IFG'(IFG_WORDS - 1);
  localparam logic [W_FRAME_WORDS-1:0] REM_ONE  = W_FRAME_WORDS'(1);

  tx_ctrl_state_e           r_state,   w_state_nxt;
  logic [W_FRAME_WORDS-1:0] r_rem,     w_rem_nxt;
  logic [W_MAC_HDR_CNT-1:0] r_hdr_cnt, w_hdr_cnt_nxt;
  logic [W_IFG-1:0]         r_ifg_cnt, w_ifg_cnt_nxt;
  logic                     w_run;
  logic                     w_start;

  // Reset is folded in so the Mealy pulses are quiet while reset is held.
  assign w_run   = i_clk_en & i_reset_n;
  assign w_start = i_frame_rdy && (i_frame_words != '0);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state   <= IDLE;
      r_rem     <= '0;
      r_hdr_cnt <= '0;
      r_ifg_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_rem     <= w_rem_nxt;
      r_hdr_cnt <= w_hdr_cnt_nxt;
      r_ifg_cnt <= w_ifg_cnt_nxt;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // skips an assignment would otherwise infer a latch.
    w_state_nxt   = r_state;
    w_rem_nxt     = r_rem;
    w_hdr_cnt_nxt = r_hdr_cnt;
    w_ifg_cnt_nxt = r_ifg_cnt;
    o_frame_ack   = 1'b0;
    o_buf_ren     = 1'b0;
    o_frame_abort = 1'b0;

    if (w_run) begin
      unique case (r_state)
        IDLE: begin
          if (i_frame_rdy) begin
            o_frame_ack = 1'b1;
            if (w_start) begin
              w_rem_nxt     = i_frame_words;
              w_hdr_cnt_nxt = '0;
              w_state_nxt   = HDR;
            end
          end
        end
        HDR: begin
          if (r_hdr_cnt == HDR_LAST) begin
            o_buf_ren   = 1'b1;
            w_state_nxt = DATA;
          end else begin
            w_hdr_cnt_nxt = r_hdr_cnt + 1'b1;
          end
        end
        DATA: begin
          // The word prefetched in HDR means the last data cycle issues no read.
          if (i_buf_underflow) begin
            o_frame_abort = 1'b1;
            w_state_nxt   = ERR;
          end else if (r_rem > REM_ONE) begin
            o_buf_ren = 1'b1;
            w_rem_nxt = r_rem - 1'b1;
          end else begin
            w_ifg_cnt_nxt = IFG_LOAD;
            w_state_nxt   = IFG;
          end
        end
        ERR: begin
          w_ifg_cnt_nxt = IFG_LOAD;
          w_state_nxt   = IFG;
        end
        IFG: begin
          if (r_ifg_cnt != '0) begin
            w_ifg_cnt_nxt = r_ifg_cnt - 1'b1;
          end else if (w_start) begin
            o_frame_ack   = 1'b1;
            w_rem_nxt     = i_frame_words;
            w_hdr_cnt_nxt = '0;
            w_state_nxt   = HDR;
          end else begin
            w_state_nxt = IDLE;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  assign o_gen_idle  = (r_state == IDLE);
  assign o_gen_hdr   = (r_state == HDR);
  assign o_gen_data  = (r_state == DATA);
  assign o_gen_error = (r_state == ERR);
  assign o_gen_ifg   = (r_state == IFG);
  assign o_hdr_id    = (r_state == HDR) ? r_hdr_cnt : '0;
  assign o_busy      = (r_state != IDLE);

  a_gen_onehot: assert property (@(posedge i_clk) disable iff (!i_reset_n)
    $onehot({o_gen_hdr, o_gen_data, o_gen_idle, o_gen_ifg, o_gen_error}));

endmodule
